// File: rtl/target_pkg.sv
// Shared types and LFSR tap constants for the target selector.
package target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } sel_state_t;

  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;

  // Tap constant for a supported LFSR width, zero-extended to 32 bits.
  function automatic logic [31:0] taps_for(input int unsigned width);
    case (width)
      8:       return {24'h0, TAPS8};
      16:      return {16'h0, TAPS16};
      default: return TAPS32;
    endcase
  endfunction

endpackage

// File: rtl/target_selector_if.sv
// Request/response bundle between a draw requester and target_selector.
interface target_selector_if #(
  parameter int unsigned LFSR_WIDTH = 32,
  parameter int unsigned TW         = 4
);
  logic                  seed_load;
  logic [LFSR_WIDTH-1:0] seed;
  logic [31:0]           mix;
  logic                  req;
  logic                  busy;
  logic                  valid;
  logic [TW-1:0]         target;
  logic [LFSR_WIDTH-1:0] rand_raw;

  modport master (
    output seed_load, seed, mix, req,
    input  busy, valid, target, rand_raw
  );

  modport slave (
    input  seed_load, seed, mix, req,
    output busy, valid, target, rand_raw
  );
endinterface

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with a zero-safe parallel load.
module lfsr_core #(
  parameter int unsigned         WIDTH = 32,
  parameter logic [WIDTH-1:0]    TAPS  = '1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_val
);

  // Right-shifting Galois step: taps are applied when the bit shifted out is 1.
  always_comb begin
    next_val = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);
  end

  // State register; an all-zero load would lock the LFSR, so it becomes 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= WIDTH'(1);
    end else if (load) begin
      state <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      state <= next_val;
    end
  end

endmodule

// File: rtl/target_selector.sv
// Draws a pseudo-random target index in 0..NUM_TARGETS-1 with rejection sampling,
// an optional no-immediate-repeat rule and a deterministic fallback.
module target_selector
  import target_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH  = 32,
  parameter int unsigned NUM_TARGETS = 10,
  parameter int unsigned NO_REPEAT   = 1,
  parameter int unsigned MAX_TRIES   = 16
) (
  input  logic        clock,
  input  logic        resetn,
  target_selector_if.slave bus
);

  localparam int unsigned TW    = ($clog2(NUM_TARGETS) > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned TRY_W = ($clog2(MAX_TRIES) > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW:0]           NT       = (TW+1)'(NUM_TARGETS);
  localparam logic [TRY_W-1:0]      LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [LFSR_WIDTH-1:0] TAPS     = LFSR_WIDTH'(taps_for(LFSR_WIDTH));

  sel_state_t            state;
  logic [TRY_W-1:0]      tries;
  logic [TW-1:0]         last;
  logic [TW-1:0]         target_q;
  logic                  have_last;
  logic                  valid_q;
  logic                  busy_q;

  logic                  lfsr_load;
  logic [LFSR_WIDTH-1:0] lfsr_load_val;
  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_next;

  logic [TW-1:0]         cand;
  logic                  cand_ok;
  logic [TW:0]           last_inc;
  logic [TW:0]           last_wrap;
  logic [TW-1:0]         fallback;

  // Seed load and accepted requests both replace the LFSR; seed has priority.
  always_comb begin
    lfsr_load     = bus.seed_load || ((state == ST_IDLE) && bus.req);
    lfsr_load_val = bus.seed_load ? bus.seed : (lfsr_next ^ bus.mix[LFSR_WIDTH-1:0]);
  end

  lfsr_core #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clock    (clock),
    .resetn   (resetn),
    .step     (1'b1),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .state    (lfsr_q),
    .next_val (lfsr_next)
  );

  // Candidate acceptance and the wrap-around fallback (compare-and-subtract).
  always_comb begin
    cand      = lfsr_q[TW-1:0];
    cand_ok   = ({1'b0, cand} < NT) &&
                !((NO_REPEAT != 0) && have_last && (cand == last));
    last_inc  = {1'b0, last} + 1'b1;
    last_wrap = (last_inc >= NT) ? (last_inc - NT) : last_inc;
    fallback  = have_last ? last_wrap[TW-1:0] : '0;
  end

  // Draw controller with registered busy/valid/target.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      tries     <= '0;
      target_q  <= '0;
      last      <= '0;
      have_last <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (bus.seed_load) begin
      state   <= ST_IDLE;
      tries   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (bus.req) begin
            tries  <= '0;
            busy_q <= 1'b1;
            state  <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (cand_ok) begin
            target_q  <= cand;
            last      <= cand;
            have_last <= 1'b1;
            valid_q   <= 1'b1;
            state     <= ST_DONE;
          end else if (tries == LAST_TRY) begin
            target_q  <= fallback;
            last      <= fallback;
            have_last <= 1'b1;
            valid_q   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.target   = target_q;
  assign bus.rand_raw = lfsr_q;

endmodule

// File: tb/tb_target_selector.sv
// Randomized bench for target_selector: three configurations checked every cycle
// against a draw-level model, plus hand-computed directed cases.
module tb_target_selector;
  import target_pkg::*;

  localparam int unsigned PW  [3] = '{32, 8, 16};
  localparam int unsigned PN  [3] = '{10, 10, 2};
  localparam int unsigned PNR [3] = '{1, 1, 1};
  localparam int unsigned PMT [3] = '{16, 1, 16};
  localparam int unsigned PTW [3] = '{4, 4, 1};

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        sl_v   [3];
  logic        req_v  [3];
  logic [31:0] seed_v [3];
  logic [31:0] mix_v  [3];
  logic        o_busy  [3];
  logic        o_valid [3];
  logic [31:0] o_target[3];
  logic [31:0] o_raw   [3];

  target_selector_if #(.LFSR_WIDTH(32), .TW(4)) if0 ();
  target_selector_if #(.LFSR_WIDTH(8),  .TW(4)) if1 ();
  target_selector_if #(.LFSR_WIDTH(16), .TW(1)) if2 ();

  target_selector #(.LFSR_WIDTH(32), .NUM_TARGETS(10), .NO_REPEAT(1), .MAX_TRIES(16))
    dut0 (.clock(clock), .resetn(resetn), .bus(if0));
  target_selector #(.LFSR_WIDTH(8), .NUM_TARGETS(10), .NO_REPEAT(1), .MAX_TRIES(1))
    dut1 (.clock(clock), .resetn(resetn), .bus(if1));
  target_selector #(.LFSR_WIDTH(16), .NUM_TARGETS(2), .NO_REPEAT(1), .MAX_TRIES(16))
    dut2 (.clock(clock), .resetn(resetn), .bus(if2));

  assign if0.seed_load = sl_v[0];  assign if0.req = req_v[0];
  assign if1.seed_load = sl_v[1];  assign if1.req = req_v[1];
  assign if2.seed_load = sl_v[2];  assign if2.req = req_v[2];
  assign if0.seed = seed_v[0];     assign if0.mix = mix_v[0];
  assign if1.seed = seed_v[1][7:0]; assign if1.mix = mix_v[1];
  assign if2.seed = seed_v[2][15:0]; assign if2.mix = mix_v[2];
  assign o_busy[0] = if0.busy;  assign o_valid[0] = if0.valid;
  assign o_busy[1] = if1.busy;  assign o_valid[1] = if1.valid;
  assign o_busy[2] = if2.busy;  assign o_valid[2] = if2.valid;
  assign o_target[0] = {28'h0, if0.target};
  assign o_target[1] = {28'h0, if1.target};
  assign o_target[2] = {31'h0, if2.target};
  assign o_raw[0] = if0.rand_raw;
  assign o_raw[1] = {24'h0, if1.rand_raw};
  assign o_raw[2] = {16'h0, if2.rand_raw};

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_lfsr  [3];
  int          m_left  [3];   // cycles the block stays busy; 1 means the result cycle
  logic [31:0] m_plan  [3];
  logic [31:0] m_target[3];
  logic [31:0] m_last  [3];
  logic        m_have  [3];
  int          mhist   [10];
  int          hist    [10];

  function automatic logic [31:0] pmask(input int i);
    return (PW[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << PW[i]) - 32'd1);
  endfunction

  function automatic logic [31:0] tap_of(input int i);
    return taps_for(PW[i]);
  endfunction

  function automatic logic [31:0] m_next(input int i, input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ tap_of(i);
    return r & pmask(i);
  endfunction

  function automatic logic [31:0] nz(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  task automatic m_step(input int i);
    logic [31:0] l, c;
    bit done;
    if (sl_v[i]) begin
      m_lfsr[i] = nz(seed_v[i] & pmask(i));
      m_left[i] = 0;
    end else if (m_left[i] == 0 && req_v[i]) begin
      m_lfsr[i] = nz((m_next(i, m_lfsr[i]) ^ mix_v[i]) & pmask(i));
      // Resolve the whole draw now from the LFSR sequence it will see.
      l = m_lfsr[i];
      done = 0;
      for (int t = 1; t <= int'(PMT[i]) && !done; t++) begin
        c = l & ((32'd1 << PTW[i]) - 32'd1);
        if (c < PN[i] && !(PNR[i] != 0 && m_have[i] && c == m_last[i])) begin
          m_plan[i] = c; m_left[i] = t + 1; done = 1;
        end else if (t == int'(PMT[i])) begin
          m_plan[i] = m_have[i] ? ((m_last[i] + 1) % PN[i]) : 32'd0;
          m_left[i] = t + 1; done = 1;
        end
        l = m_next(i, l);
      end
    end else begin
      m_lfsr[i] = m_next(i, m_lfsr[i]);
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 1) begin
          m_target[i] = m_plan[i];
          m_last[i]   = m_plan[i];
          m_have[i]   = 1'b1;
          if (i == 0) mhist[m_plan[i]]++;
        end
      end
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        m_lfsr[i] = 32'd1; m_left[i] = 0; m_plan[i] = '0;
        m_target[i] = '0; m_last[i] = '0; m_have[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) m_step(i);
    end
  end

  // ---------------- compare process ----------------
  int   n_draw0 = 0;
  int   n_draw2 = 0;
  logic [31:0] prev2;
  bit   have_prev2 = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("busy",     i, {31'h0, o_busy[i]},  {31'h0, m_left[i] != 0});
        check("valid",    i, {31'h0, o_valid[i]}, {31'h0, m_left[i] == 1});
        check("target",   i, o_target[i], m_target[i]);
        check("rand_raw", i, o_raw[i],    m_lfsr[i]);
      end
      if (o_valid[0]) begin
        n_draw0++;
        check("range0", 0, {31'h0, o_target[0] < 32'd10}, 32'd1);
        if (o_target[0] < 32'd10) hist[o_target[0]]++;
      end
      if (o_valid[2]) begin
        n_draw2++;
        if (have_prev2) check("no_repeat", 2, {31'h0, o_target[2] == prev2}, 32'd0);
        prev2 = o_target[2];
        have_prev2 = 1;
      end
    end
  end

  // Directed draw steering the first candidate to 'want'; checks target and latency.
  task automatic forced_draw(input int i, input logic [31:0] want, input logic [31:0] exp_tgt);
    int n;
    logic [31:0] got;
    mix_v[i] = ((m_next(i, m_lfsr[i]) ^ want) & pmask(i)) | ($urandom & ~pmask(i));
    req_v[i] = 1'b1;
    n = 0;
    got = 32'hFFFF_FFFF;
    do begin
      @(posedge clock); #1;
      n++;
      req_v[i] = 1'b0;
      if (o_valid[i]) got = o_target[i];
    end while ((o_busy[i] || n == 1) && n < 40);
    check("forced_tgt", i, got, exp_tgt);
    check("forced_lat", i, n, 32'd3);
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      sl_v[i] = 0; req_v[i] = 0; seed_v[i] = '0; mix_v[i] = '0;
    end
    for (int v = 0; v < 10; v++) begin hist[v] = 0; mhist[v] = 0; end
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_busy",  i, {31'h0, o_busy[i]},  32'd0);
      check("rst_valid", i, {31'h0, o_valid[i]}, 32'd0);
      check("rst_tgt",   i, o_target[i], 32'd0);
      check("rst_raw",   i, o_raw[i],    32'd1);
    end
    resetn = 1'b1;
    chk_en = 1'b1;

    // Zero seed must load as 1.
    for (int i = 0; i < 3; i++) begin sl_v[i] = 1'b1; seed_v[i] = '0; end
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      sl_v[i] = 1'b0;
      check("seed0_raw", i, o_raw[i], 32'd1);
    end

    // Directed targets, including forced rejections into the fallback.
    forced_draw(0, 32'h0000_0007, 32'd7);
    forced_draw(2, 32'h0000_0001, 32'd1);
    forced_draw(1, 32'h03, 32'd3);
    forced_draw(1, 32'h03, 32'd4);   // repeat of last=3 rejected -> 4
    forced_draw(1, 32'h09, 32'd9);
    forced_draw(1, 32'h09, 32'd0);   // repeat of last=9 rejected -> wraps to 0
    forced_draw(1, 32'h0E, 32'd1);   // out of range -> last(0)+1

    // seed_load in the DRAW cycle aborts; seed_load with req starts nothing.
    mix_v[0] = $urandom;
    req_v[0] = 1'b1;
    @(posedge clock); #1;
    check("draw_busy", 0, {31'h0, o_busy[0]}, 32'd1);
    sl_v[0] = 1'b1; seed_v[0] = 32'h1234_5678;
    @(posedge clock); #1;
    check("abort_busy",  0, {31'h0, o_busy[0]},  32'd0);
    check("abort_valid", 0, {31'h0, o_valid[0]}, 32'd0);
    check("abort_raw",   0, o_raw[0], 32'h1234_5678);
    seed_v[0] = 32'h0BAD_F00D;
    @(posedge clock); #1;
    sl_v[0] = 1'b0; req_v[0] = 1'b0;
    check("sl_req_busy", 0, {31'h0, o_busy[0]}, 32'd0);
    check("sl_req_raw",  0, o_raw[0], 32'h0BAD_F00D);
    repeat (2) @(posedge clock); #1;
    check("tgt_kept", 0, o_target[0], 32'd7);

    // Asynchronous reset pulse in the middle of a draw.
    mix_v[0] = $urandom;
    req_v[0] = 1'b1;
    @(posedge clock); #1;
    req_v[0] = 1'b0;
    check("pre_rst_busy", 0, {31'h0, o_busy[0]}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("arst_busy",  0, {31'h0, o_busy[0]},  32'd0);
    check("arst_valid", 0, {31'h0, o_valid[0]}, 32'd0);
    check("arst_tgt",   0, o_target[0], 32'd0);
    check("arst_raw",   0, o_raw[0],    32'd1);
    resetn = 1'b1;

    // Randomized back-to-back traffic.
    @(posedge clock); #1;
    n_draw0 = 0;
    cyc = 0;
    while (n_draw0 < 10000 && cyc < 60000) begin
      req_v[0] = 1'b1; mix_v[0] = $urandom;
      req_v[1] = 1'($urandom_range(0, 1)); mix_v[1] = $urandom;
      sl_v[1]  = ($urandom_range(0, 19) == 0);
      seed_v[1] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      req_v[2] = 1'b1; mix_v[2] = $urandom;
      @(posedge clock); #1;
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin req_v[i] = 0; sl_v[i] = 0; end
    check("draws0_done", 0, {31'h0, n_draw0 >= 10000}, 32'd1);
    check("draws2_done", 2, {31'h0, n_draw2 >= 200},   32'd1);
    repeat (4) @(posedge clock); #1;
    for (int v = 0; v < 10; v++) begin
      check("hist",         v, hist[v], mhist[v]);
      check("hist_nonzero", v, {31'h0, hist[v] != 0}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
